quiz_round_timer: RTL
=====================

// Module: quiz_round_timer
// PURPOSE
//   Avalon-MM slave that runs the per-question countdown for the quiz game.
//   Samples the 2-bit difficulty from the difficulty PIO's out_port at START and loads that difficulty's time limit.
//   Decrements once per tick until zero, then flags expiry and raises an optional IRQ to the Nios.
//   Sits on the same bus as the game PIOs; time_left also drives the hex display.
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per countdown tick (1 s at 50 MHz); must be >= 2
//   T_EASY     30          ticks loaded for difficulty 2'd0; all T_* must be 1..255
//   T_MED      20          ticks loaded for difficulty 2'd1
//   T_HARD     10          ticks loaded for difficulty 2'd2
//   T_EXPERT   5           ticks loaded for difficulty 2'd3
// PORTS
//   clk         in   1   system clock
//   reset_n     in   1   asynchronous, active-low reset
//   difficulty  in   2   from difficulty PIO out_port; sampled only on START
//   address     in   2   Avalon word address
//   chipselect  in   1   Avalon chipselect
//   write_n     in   1   Avalon write strobe, active-low
//   writedata   in   32  Avalon write data
//   readdata    out  32  Avalon read data, combinational from address (0 wait states)
//   time_left   out  8   remaining ticks
//   running     out  1   1 while state == RUN
//   expired     out  1   sticky expiry flag
//   irq         out  1   expired & irq_en, registered
// BEHAVIOUR
// - Reset values: state IDLE, time_left 0, prescaler 0, irq_en 0, expired 0, irq 0, readdata follows regs.
// - Register map, write = chipselect & ~write_n:
//   - 0 CTRL, write-only commands; reads return STATUS {29'b0, expired, paused, running}.
//     - bit0 START, bit1 STOP, bit2 PAUSE, bit3 RESUME.
//   - 1 TIME, read-only {24'b0, time_left}; writes ignored.
//   - 2 IRQ_EN, r/w bit0; readdata {31'b0, irq_en}.
//   - 3 EVENT, read {31'b0, expired}; write bit0 = 1 clears expired (and irq next cycle).
// - FSM states IDLE, RUN, PAUSE, DONE. Command priority within one write: STOP > START > PAUSE > RESUME.
//   - START (any state):
//     - time_left <= lookup(difficulty) in that cycle.
//     - prescaler <= 0, expired <= 0, next state RUN.
//   - STOP (any state): time_left <= 0, prescaler <= 0, next state IDLE; expired unchanged.
//   - PAUSE: RUN -> PAUSE, prescaler and time_left frozen; ignored in other states.
//   - RESUME: PAUSE -> RUN, prescaler continues from frozen value; ignored in other states.
// - RUN counting:
//   - prescaler counts 0..TICK_DIV-1 and wraps; the tick is the cycle prescaler == TICK_DIV-1.
//   - On a tick, time_left decrements.
//   - If time_left == 1 on a tick: time_left <= 0, state DONE, expired <= 1 in the same edge.
// - DONE: counters hold; only START or STOP leave DONE. expired is sticky until EVENT clear or START.
// - Simultaneous events:
//   - Command write and tick in the same cycle: the command wins and the tick is discarded.
//   - EVENT clear and expiry in the same cycle: expiry wins, expired stays 1.
// - difficulty changes while not starting have no effect; the first decrement is TICK_DIV cycles after START.
// - irq <= expired & irq_en each cycle (1-cycle latency); clearing irq_en drops irq next cycle.
// - Reset asserted mid-count returns everything to the reset values immediately; no command is remembered.
// TESTING (bench uses TICK_DIV=4)
// - Reset, read addr0/1/3 -> all readdata 0, irq 0, running 0.
// - difficulty=2'd3, write CTRL=1 -> time_left 5, running 1.
//   - Decrements every 4 clks; 20 clks after START time_left 0, expired 1, STATUS 0x4.
// - irq_en=1, expire at T_EXPERT -> irq 1 one clk after expired.
//   - Write EVENT=1 -> expired 0, irq 0 on the following clk.
// - difficulty=0, START, run 6 clks, PAUSE for 40 clks -> time_left frozen at 29.
//   - RESUME -> next decrement 2 clks later (prescaler resumes from 2).
// - CTRL=0x3 written in RUN -> STOP wins: IDLE, time_left 0, running 0.
//   - START on the tick cycle -> reload to full value, no decrement.
// - Assert reset_n low mid-count at time_left 7 -> all outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/quiz_round_timer.sv
// Per-question countdown timer on the Avalon-MM bus: loads a difficulty-dependent
// limit on START, decrements once per prescaled tick, and flags expiry with an optional IRQ.
module quiz_round_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int T_EASY   = 30,
    parameter int T_MED    = 20,
    parameter int T_HARD   = 10,
    parameter int T_EXPERT = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  difficulty,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  time_left,
    output logic        running,
    output logic        expired,
    output logic        irq
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t          state_q;
    logic [PW-1:0]   pre_q;
    logic [7:0]      time_q;
    logic            expired_q;
    logic            irq_en_q;
    logic            irq_q;

    logic            wr_en;
    logic            ctrl_wr;
    logic            unused_wd;

    function automatic logic [7:0] limit_for(input logic [1:0] d);
        case (d)
            2'd0:    return 8'(T_EASY);
            2'd1:    return 8'(T_MED);
            2'd2:    return 8'(T_HARD);
            default: return 8'(T_EXPERT);
        endcase
    endfunction

    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en && (address == 2'd0);
    assign unused_wd = ^writedata[31:4];

    // A CTRL write carrying any command bit owns the cycle, so a coincident tick is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            time_q    <= 8'd0;
            expired_q <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= expired_q & irq_en_q;
            if (wr_en && address == 2'd2)
                irq_en_q <= writedata[0];
            if (wr_en && address == 2'd3 && writedata[0])
                expired_q <= 1'b0;

            if (ctrl_wr && writedata[1]) begin
                state_q <= IDLE;
                time_q  <= 8'd0;
                pre_q   <= '0;
            end else if (ctrl_wr && writedata[0]) begin
                state_q   <= RUN;
                time_q    <= limit_for(difficulty);
                pre_q     <= '0;
                expired_q <= 1'b0;
            end else if (ctrl_wr && writedata[2]) begin
                if (state_q == RUN)
                    state_q <= PAUSE;
            end else if (ctrl_wr && writedata[3]) begin
                if (state_q == PAUSE)
                    state_q <= RUN;
            end else if (state_q == RUN) begin
                if (pre_q == PRE_MAX) begin
                    pre_q <= '0;
                    // Expiry is written last so it overrides a same-cycle EVENT clear.
                    if (time_q == 8'd1) begin
                        time_q    <= 8'd0;
                        state_q   <= DONE;
                        expired_q <= 1'b1;
                    end else begin
                        time_q <= time_q - 8'd1;
                    end
                end else begin
                    pre_q <= pre_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = {29'd0, expired_q, state_q == PAUSE, state_q == RUN};
            2'd1: readdata = {24'd0, time_q};
            2'd2: readdata = {31'd0, irq_en_q};
            default: readdata = {31'd0, expired_q};
        endcase
    end

    assign time_left = time_q;
    assign running   = (state_q == RUN);
    assign expired   = expired_q;
    assign irq       = irq_q;

endmodule
